// File: rtl/hsid_fifo_seq.sv
// hsid_fifo_seq: sequencer for the HSID spectral-band FIFO.
// It clears the FIFO and loads one reference spectrum of num_bands words from an
// upstream valid/ready stream. It then recirculates that spectrum in loop mode
// for num_passes passes and presents every band downstream.
//
// Handshake rules (both streams): a word moves in the cycle where valid && ready
// are both high at the rising clock edge. The upstream side (in_valid/in_ready)
// does not require valid to stay up while waiting. The downstream side
// (out_valid/out_ready) holds out_valid and the FIFO data steady until it is
// accepted.
module hsid_fifo_seq #(
  parameter int WORD_WIDTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int PASS_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [FIFO_ADDR_WIDTH:0]   num_bands,
  input  logic [PASS_WIDTH-1:0]      num_passes,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_WIDTH-1:0]      in_data,
  output logic                       fifo_clear,
  output logic                       fifo_wr_en,
  output logic                       fifo_rd_en,
  output logic                       fifo_loop_en,
  output logic [WORD_WIDTH-1:0]      fifo_data_in,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last_band,
  output logic                       out_last_pass,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_LOOP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // DEPTH itself is a legal band count, which is why counts are one bit wider than the address.
  localparam logic [FIFO_ADDR_WIDTH:0] depth_c  = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
  localparam logic [FIFO_ADDR_WIDTH:0] one_band = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PASS_WIDTH-1:0]    one_pass = {{(PASS_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]                 state;
  logic [FIFO_ADDR_WIDTH:0]   nb_q;
  logic [PASS_WIDTH-1:0]      np_q;
  logic [FIFO_ADDR_WIDTH:0]   load_cnt;
  logic [FIFO_ADDR_WIDTH:0]   band_idx;
  logic [PASS_WIDTH-1:0]      pass_idx;
  logic [FIFO_ADDR_WIDTH:0]   nb_m1;
  logic [PASS_WIDTH-1:0]      np_m1;
  logic                       start_illegal;
  logic                       issue_last_band;
  logic                       issue_last_pass;

  // The load count alone tracks occupancy, so the empty flag is not used for sequencing.
  logic unused_fifo_empty;
  assign unused_fifo_empty = fifo_empty;

  assign nb_m1 = nb_q - one_band;
  assign np_m1 = np_q - one_pass;

  assign start_illegal = (num_bands == '0) || (num_bands > depth_c) || (num_passes == '0);

  assign issue_last_band = (band_idx == nb_m1);
  assign issue_last_pass = (pass_idx == np_m1);

  // The upstream stream writes straight into the FIFO while loading.
  assign in_ready     = (state == S_LOAD);
  assign fifo_wr_en   = in_ready && in_valid;
  assign fifo_data_in = in_ready ? in_data : '0;

  // The sequencer never pops; it only recirculates.
  assign fifo_rd_en = 1'b0;

  // Issue a new band only when the output register is free or is being drained this cycle.
  assign fifo_loop_en = (state == S_LOOP) && (!out_valid || out_ready);

  assign busy = (state != S_IDLE);

  // Main sequencer: state, counters, registered FIFO clear, output markers and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      nb_q          <= '0;
      np_q          <= '0;
      load_cnt      <= '0;
      band_idx      <= '0;
      pass_idx      <= '0;
      fifo_clear    <= 1'b0;
      out_valid     <= 1'b0;
      out_last_band <= 1'b0;
      out_last_pass <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      fifo_clear <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      if (busy && abort) begin
        // Abort wins over every other event. The FIFO is cleared so that no stale spectrum survives.
        state         <= S_IDLE;
        fifo_clear    <= 1'b1;
        out_valid     <= 1'b0;
        out_last_band <= 1'b0;
        out_last_pass <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (start_illegal) begin
                error <= 1'b1;
              end else begin
                nb_q       <= num_bands;
                np_q       <= num_passes;
                fifo_clear <= 1'b1;
                state      <= S_CLEAR;
              end
            end
          end
          S_CLEAR: begin
            load_cnt <= '0;
            band_idx <= '0;
            pass_idx <= '0;
            state    <= S_LOAD;
          end
          S_LOAD: begin
            if (fifo_full) begin
              // A full FIFO while loading means the clear did not take effect; give up the job.
              error      <= 1'b1;
              fifo_clear <= 1'b1;
              state      <= S_IDLE;
            end else if (fifo_wr_en) begin
              if (load_cnt == nb_m1) begin
                load_cnt <= '0;
                state    <= S_LOOP;
              end else begin
                load_cnt <= load_cnt + one_band;
              end
            end
          end
          S_LOOP: begin
            if (fifo_loop_en) begin
              // FIFO data_out is registered, so the markers travel one cycle behind the issue.
              out_valid     <= 1'b1;
              out_last_band <= issue_last_band;
              out_last_pass <= issue_last_pass;
              if (issue_last_band) begin
                band_idx <= '0;
                if (issue_last_pass) begin
                  state <= S_DRAIN;
                end else begin
                  pass_idx <= pass_idx + one_pass;
                end
              end else begin
                band_idx <= band_idx + one_band;
              end
            end
          end
          S_DRAIN: begin
            if (out_valid && out_ready) begin
              out_valid     <= 1'b0;
              out_last_band <= 1'b0;
              out_last_pass <= 1'b0;
              done          <= 1'b1;
              state         <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
